// File: rtl/pacman_dir_pkg.sv
// Direction encodings and FSM state type shared by the ghost motion blocks.
// Directions are one-hot so a request can be validated with a single population check.
package pacman_dir_pkg;

  localparam logic [3:0] DIR_NONE  = 4'b0000;
  localparam logic [3:0] DIR_DOWN  = 4'b0001;
  localparam logic [3:0] DIR_RIGHT = 4'b0010;
  localparam logic [3:0] DIR_UP    = 4'b0100;
  localparam logic [3:0] DIR_LEFT  = 4'b1000;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_DIR = 2'd1,
    MOVE     = 2'd2
  } ghost_state_t;

  function automatic logic is_onehot4(input logic [3:0] dir);
    return (dir != 4'b0000) && ((dir & (dir - 4'd1)) == 4'b0000);
  endfunction

endpackage

// File: rtl/dir_request_filter.sv
// Latches the most recent legal (one-hot) direction request until the FSM consumes it.
// A fresh legal request in the same cycle as a consume wins, so it is never lost.
module dir_request_filter
  import pacman_dir_pkg::*;
(
  input  logic       clk,
  input  logic       resetN,
  input  logic [3:0] dir_req,
  input  logic       clear,
  output logic [3:0] pending
);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pending <= DIR_NONE;
    end else if (is_onehot4(dir_req)) begin
      pending <= dir_req;
    end else if (clear) begin
      pending <= DIR_NONE;
    end
  end

endmodule

// File: rtl/ghost_move_ctrl.sv
// Frame-rate ghost motion FSM: applies one-hot direction requests, steps the top-left
// position, backs off on wall collision or edge clamp and requests new directions.
module ghost_move_ctrl
  import pacman_dir_pkg::*;
#(
  parameter int unsigned INIT_X       = 300,
  parameter int unsigned INIT_Y       = 200,
  parameter int unsigned SPEED        = 1,
  parameter int unsigned X_MIN        = 0,
  parameter int unsigned X_MAX        = 608,
  parameter int unsigned Y_MIN        = 0,
  parameter int unsigned Y_MAX        = 448,
  parameter int unsigned REQ_PERIOD   = 32,
  parameter int unsigned WAIT_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        enable,
  input  logic [3:0]  dirReq,
  input  logic        collision,
  output logic [10:0] topLeftX,
  output logic [10:0] topLeftY,
  output logic [3:0]  curDir,
  output logic        newDirReq,
  output logic        stuck
);

  localparam logic [11:0] SPEED12 = 12'(SPEED);
  localparam logic [11:0] X_MIN12 = 12'(X_MIN);
  localparam logic [11:0] X_MAX12 = 12'(X_MAX);
  localparam logic [11:0] Y_MIN12 = 12'(Y_MIN);
  localparam logic [11:0] Y_MAX12 = 12'(Y_MAX);
  localparam logic [7:0]  WAIT_LAST = 8'(WAIT_TIMEOUT - 1);
  localparam logic [7:0]  RUN_LAST  = 8'(REQ_PERIOD - 1);

  ghost_state_t state_reg, state_next;
  logic [10:0]  x_reg, x_next, y_reg, y_next;
  logic [10:0]  saved_x_reg, saved_x_next, saved_y_reg, saved_y_next;
  logic [3:0]   dir_reg, dir_next, blocked_reg, blocked_next;
  logic [7:0]   wait_cnt_reg, wait_cnt_next, run_cnt_reg, run_cnt_next;
  logic         req_reg, req_next, stuck_reg, stuck_next;
  logic         col_flag_reg, col_flag_next, first_reg, first_next;
  logic [3:0]   pending;
  logic         clear_pending;
  logic         col_now;

  // Step candidates in 12 bits; bit 11 of a minus result flags wrap below zero.
  logic [11:0]  x_plus, x_minus, y_plus, y_minus;
  logic [12:0]  x_low_diff, y_low_diff;
  logic [10:0]  step_x, step_y, edge_x, edge_y;
  logic         hit_edge;

  dir_request_filter u_filter (
    .clk     (clk),
    .resetN  (resetN),
    .dir_req (dirReq),
    .clear   (clear_pending),
    .pending (pending)
  );

  assign x_plus     = {1'b0, x_reg} + SPEED12;
  assign x_minus    = {1'b0, x_reg} - SPEED12;
  assign y_plus     = {1'b0, y_reg} + SPEED12;
  assign y_minus    = {1'b0, y_reg} - SPEED12;
  assign x_low_diff = {1'b0, x_minus} - {1'b0, X_MIN12};
  assign y_low_diff = {1'b0, y_minus} - {1'b0, Y_MIN12};

  always_comb begin
    step_x   = x_reg;
    step_y   = y_reg;
    edge_x   = x_reg;
    edge_y   = y_reg;
    hit_edge = 1'b0;
    case (dir_reg)
      DIR_DOWN: begin
        step_y = y_plus[10:0];
        if (y_plus > Y_MAX12) begin
          hit_edge = 1'b1;
          edge_y   = Y_MAX12[10:0];
        end
      end
      DIR_UP: begin
        step_y = y_minus[10:0];
        if (y_minus[11] || y_low_diff[12]) begin
          hit_edge = 1'b1;
          edge_y   = Y_MIN12[10:0];
        end
      end
      DIR_RIGHT: begin
        step_x = x_plus[10:0];
        if (x_plus > X_MAX12) begin
          hit_edge = 1'b1;
          edge_x   = X_MAX12[10:0];
        end
      end
      DIR_LEFT: begin
        step_x = x_minus[10:0];
        if (x_minus[11] || x_low_diff[12]) begin
          hit_edge = 1'b1;
          edge_x   = X_MIN12[10:0];
        end
      end
      default: ;
    endcase
  end

  // A collision coinciding with the frame tick belongs to the frame being evaluated.
  assign col_now = col_flag_reg | collision;

  always_comb begin
    state_next    = state_reg;
    x_next        = x_reg;
    y_next        = y_reg;
    saved_x_next  = saved_x_reg;
    saved_y_next  = saved_y_reg;
    dir_next      = dir_reg;
    blocked_next  = blocked_reg;
    wait_cnt_next = wait_cnt_reg;
    run_cnt_next  = run_cnt_reg;
    first_next    = first_reg;
    req_next      = 1'b0;
    clear_pending = 1'b0;
    col_flag_next = startOfFrame ? 1'b0 : col_now;

    if (!enable) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          state_next    = WAIT_DIR;
          first_next    = 1'b1;
          wait_cnt_next = 8'd0;
        end
        WAIT_DIR: begin
          if (startOfFrame) begin
            if (first_reg) begin
              req_next      = 1'b1;
              first_next    = 1'b0;
              wait_cnt_next = 8'd0;
            end else if (is_onehot4(pending) && (pending != blocked_reg)) begin
              dir_next      = pending;
              clear_pending = 1'b1;
              blocked_next  = DIR_NONE;
              saved_x_next  = x_reg;
              saved_y_next  = y_reg;
              run_cnt_next  = 8'd0;
              state_next    = MOVE;
            end else if (wait_cnt_reg == WAIT_LAST) begin
              req_next      = 1'b1;
              wait_cnt_next = 8'd0;
            end else begin
              wait_cnt_next = wait_cnt_reg + 8'd1;
            end
          end
        end
        MOVE: begin
          if (startOfFrame) begin
            if (col_now || hit_edge) begin
              // Leaving MOVE already pulses, so the wait that follows does not add an entry pulse.
              x_next        = col_now ? saved_x_reg : edge_x;
              y_next        = col_now ? saved_y_reg : edge_y;
              blocked_next  = dir_reg;
              dir_next      = DIR_NONE;
              req_next      = 1'b1;
              wait_cnt_next = 8'd0;
              first_next    = 1'b0;
              state_next    = WAIT_DIR;
            end else begin
              saved_x_next = x_reg;
              saved_y_next = y_reg;
              x_next       = step_x;
              y_next       = step_y;
              if (is_onehot4(pending)) begin
                dir_next      = pending;
                clear_pending = 1'b1;
              end
              if (run_cnt_reg == RUN_LAST) begin
                req_next     = 1'b1;
                run_cnt_next = 8'd0;
              end else begin
                run_cnt_next = run_cnt_reg + 8'd1;
              end
            end
          end
        end
        default: state_next = WAIT_DIR;
      endcase
    end

    stuck_next = (state_next == WAIT_DIR);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_reg    <= WAIT_DIR;
      x_reg        <= 11'(INIT_X);
      y_reg        <= 11'(INIT_Y);
      saved_x_reg  <= 11'(INIT_X);
      saved_y_reg  <= 11'(INIT_Y);
      dir_reg      <= DIR_NONE;
      blocked_reg  <= DIR_NONE;
      wait_cnt_reg <= 8'd0;
      run_cnt_reg  <= 8'd0;
      first_reg    <= 1'b1;
      req_reg      <= 1'b0;
      stuck_reg    <= 1'b1;
      col_flag_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      x_reg        <= x_next;
      y_reg        <= y_next;
      saved_x_reg  <= saved_x_next;
      saved_y_reg  <= saved_y_next;
      dir_reg      <= dir_next;
      blocked_reg  <= blocked_next;
      wait_cnt_reg <= wait_cnt_next;
      run_cnt_reg  <= run_cnt_next;
      first_reg    <= first_next;
      req_reg      <= req_next;
      stuck_reg    <= stuck_next;
      col_flag_reg <= col_flag_next;
    end
  end

  assign topLeftX  = x_reg;
  assign topLeftY  = y_reg;
  assign curDir    = dir_reg;
  assign newDirReq = req_reg;
  assign stuck     = stuck_reg;

endmodule

// File: tb/tb_ghost_move_ctrl.sv
// Frame-level bench for ghost_move_ctrl: a default instance (SPEED=1) and a SPEED=2
// instance started at X=301 so that it reaches X=607 and clamps at the right edge.
module tb_ghost_move_ctrl;
  import pacman_dir_pkg::*;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        sof = 1'b0;
  logic        en_a = 1'b1, col_a = 1'b0, en_b = 1'b1, col_b = 1'b0;
  logic [3:0]  dir_a = 4'b0000, dir_b = 4'b0000;
  logic [10:0] x_a, y_a, x_b, y_b;
  logic [3:0]  cd_a, cd_b;
  logic        req_a, req_b, stuck_a, stuck_b;

  always #5 clk = ~clk;

  ghost_move_ctrl u_a (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .enable(en_a), .dirReq(dir_a),
    .collision(col_a), .topLeftX(x_a), .topLeftY(y_a), .curDir(cd_a),
    .newDirReq(req_a), .stuck(stuck_a)
  );

  ghost_move_ctrl #(.INIT_X(301), .SPEED(2)) u_b (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .enable(en_b), .dirReq(dir_b),
    .collision(col_b), .topLeftX(x_b), .topLeftY(y_b), .curDir(cd_b),
    .newDirReq(req_b), .stuck(stuck_b)
  );

  typedef struct {
    logic        en;
    logic        col;
    logic [3:0]  dir;
    logic [10:0] x;
    logic [10:0] y;
    logic [3:0]  cd;
    logic        req;
    logic        stuck;
  } vec_t;

  typedef struct {
    int          id;
    logic [10:0] x;
    logic [10:0] y;
    logic [3:0]  cd;
    logic        req;
    logic        stuck;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s frame %0d: got %0d required %0d", name, id, act, req);
    end
  endtask

  task automatic add(input logic en, input logic col, input logic [3:0] dir, input int x,
                     input int y, input logic [3:0] cd, input logic req, input logic stuck);
    vec_t v;
    v.en = en; v.col = col; v.dir = dir; v.x = 11'(x); v.y = 11'(y);
    v.cd = cd; v.req = req; v.stuck = stuck;
    tbl.push_back(v);
  endtask

  // Drive one frame on the selected instance, tick it, then compare the scoreboard head.
  task automatic run_frame(input bit sel_b, input vec_t v, input int id);
    exp_t e;
    @(negedge clk);
    if (sel_b) begin en_b = v.en; dir_b = v.dir; end
    else       begin en_a = v.en; dir_a = v.dir; end
    @(negedge clk);
    if (sel_b) col_b = v.col; else col_a = v.col;
    @(negedge clk);
    col_a = 1'b0; col_b = 1'b0;
    @(negedge clk);
    sof = 1'b1;
    e.id = id; e.x = v.x; e.y = v.y; e.cd = v.cd; e.req = v.req; e.stuck = v.stuck;
    sb.push_back(e);
    @(negedge clk);
    sof = 1'b0;
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard frame %0d: got empty queue required one entry", id);
    end else begin
      e = sb.pop_front();
      $display("%s frame %0d: x=%0d y=%0d dir=%b req=%b stuck=%b", sel_b ? "B" : "A", e.id,
               sel_b ? x_b : x_a, sel_b ? y_b : y_a, sel_b ? cd_b : cd_a,
               sel_b ? req_b : req_a, sel_b ? stuck_b : stuck_a);
      chk("topLeftX",  e.id, 32'(sel_b ? x_b : x_a), 32'(e.x));
      chk("topLeftY",  e.id, 32'(sel_b ? y_b : y_a), 32'(e.y));
      chk("curDir",    e.id, 32'(sel_b ? cd_b : cd_a), 32'(e.cd));
      chk("newDirReq", e.id, 32'(sel_b ? req_b : req_a), 32'(e.req));
      chk("stuck",     e.id, 32'(sel_b ? stuck_b : stuck_a), 32'(e.stuck));
    end
    @(negedge clk);
    chk("req_single_cycle", id, 32'(sel_b ? req_b : req_a), 32'd0);
  endtask

  function automatic vec_t b_vec(input int k);
    vec_t v;
    v.en = 1'b1; v.col = 1'b0; v.dir = (k < 6) ? DIR_DOWN : DIR_RIGHT;
    v.x = 11'd301; v.y = 11'd200; v.cd = DIR_NONE; v.req = 1'b0; v.stuck = 1'b0;
    if (k == 1) begin
      v.req = 1'b1; v.stuck = 1'b1;
    end else if (k == 2) begin
      v.cd = DIR_DOWN;
    end else if (k <= 5) begin
      v.cd = DIR_DOWN; v.y = 11'(200 + 2 * (k - 2));
    end else if (k <= 159) begin
      v.cd = DIR_RIGHT; v.y = 11'd208; v.x = 11'(301 + 2 * (k - 6));
    end else begin
      v.x = 11'd608; v.y = 11'd208; v.stuck = 1'b1; v.req = (k == 160);
    end
    // Voluntary turn request every 32 moving ticks, counted from the tick that entered MOVE.
    if (k >= 3 && k <= 159 && ((k - 2) % 32) == 0) v.req = 1'b1;
    return v;
  endfunction

  task automatic pulse_reset();
    @(negedge clk);
    resetN = 1'b0;
    repeat (2) @(negedge clk);
    resetN = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Wait-timeout and illegal requests, straight out of reset.
    for (int f = 1; f <= 17; f++)
      add(1, 0, (f <= 8) ? 4'b0000 : 4'b0011, 300, 200, DIR_NONE, (f == 1 || f == 9 || f == 17), 1);
    // Reset release, run right, collision, blocked retry, resume left, disable, re-enable.
    add(1, 0, DIR_RIGHT, 300, 200, DIR_NONE,  1, 1);
    add(1, 0, DIR_RIGHT, 300, 200, DIR_RIGHT, 0, 0);
    for (int x = 301; x <= 305; x++)
      add(1, 0, DIR_RIGHT, x, 200, DIR_RIGHT, 0, 0);
    add(1, 1, DIR_NONE,  304, 200, DIR_NONE,  1, 1);
    add(1, 0, DIR_RIGHT, 304, 200, DIR_NONE,  0, 1);
    add(1, 0, DIR_LEFT,  304, 200, DIR_LEFT,  0, 0);
    add(1, 0, DIR_LEFT,  303, 200, DIR_LEFT,  0, 0);
    add(1, 0, DIR_LEFT,  302, 200, DIR_LEFT,  0, 0);
    add(0, 0, DIR_NONE,  302, 200, DIR_LEFT,  0, 0);
    add(0, 1, DIR_NONE,  302, 200, DIR_LEFT,  0, 0);
    add(1, 0, DIR_NONE,  302, 200, DIR_LEFT,  1, 1);

    resetN = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_x",     0, 32'(x_a), 32'd300);
    chk("reset_y",     0, 32'(y_a), 32'd200);
    chk("reset_dir",   0, 32'(cd_a), 32'(DIR_NONE));
    chk("reset_req",   0, 32'(req_a), 32'd0);
    chk("reset_stuck", 0, 32'(stuck_a), 32'd1);
    resetN = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      if (i == 17) pulse_reset();
      run_frame(1'b0, tbl[i], i + 1);
    end

    // Asynchronous reset mid-frame: outputs must change before the next clock edge.
    @(negedge clk);
    #2 resetN = 1'b0;
    #1;
    chk("async_rst_x",     99, 32'(x_a), 32'd300);
    chk("async_rst_y",     99, 32'(y_a), 32'd200);
    chk("async_rst_dir",   99, 32'(cd_a), 32'(DIR_NONE));
    chk("async_rst_req",   99, 32'(req_a), 32'd0);
    chk("async_rst_stuck", 99, 32'(stuck_a), 32'd1);
    chk("async_rst_x_b",   99, 32'(x_b), 32'd301);
    @(negedge clk);
    resetN = 1'b1;

    // SPEED=2 instance: free run down, turn right, clamp at X_MAX from X=607.
    for (int k = 1; k <= 161; k++)
      run_frame(1'b1, b_vec(k), 200 + k);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
